// File: rtl/audioqsys_aud_dac_pkg.sv
// Shared constants for the Avalon-MM to I2S audio DAC transmitter.
package audioqsys_aud_dac_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int STATUS_EMPTY_BIT = 8;
    localparam int STATUS_FULL_BIT  = 9;
    localparam int STATUS_UNDER_BIT = 10;
    localparam int STATUS_OVER_BIT  = 11;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_CLR_UNDER_BIT = 1;
    localparam int CTRL_CLR_OVER_BIT  = 2;

    localparam int FRAME_SLOTS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dac_state_t;

endpackage

// File: rtl/audioqsys_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty; head word is visible on rdata.
module audioqsys_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [7:0]       level,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [LW-1:0]    level_next;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;

    // Guards use the pre-cycle flags, so a push into a full FIFO is dropped even if a pop happens too.
    assign push_ok = push & ~full_reg;
    assign pop_ok  = pop & ~empty_reg;

    always_comb begin
        level_next = level_reg + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
            full_reg  <= (level_next == LW'(DEPTH));
            empty_reg <= (level_next == '0);
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign level = 8'(level_reg);
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/audioqsys_aud_dac_tx.sv
// Avalon-MM slave that queues stereo samples and serialises them as 32-slot I2S frames.
module audioqsys_aud_dac_tx
    import audioqsys_aud_dac_pkg::*;
#(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat
);

    localparam int SLOT_CYCLES = 2 * BCLK_DIV;
    localparam int CNT_W       = $clog2(SLOT_CYCLES);
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(BCLK_DIV);

    dac_state_t        state_reg;
    dac_state_t        state_next;
    logic              enable_reg;
    logic              enable_next;
    logic              underflow_reg;
    logic              underflow_next;
    logic              overflow_reg;
    logic              overflow_next;
    logic [31:0]       readdata_reg;
    logic [31:0]       readdata_next;
    logic [31:0]       status;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [SLOT_W-1:0] slot_reg;
    logic [SLOT_W-1:0] slot_next;
    logic [SLOT_W-1:0] bit_idx;
    logic [31:0]       hold_reg;
    logic [31:0]       word_reg;
    logic [31:0]       word_next;
    logic              bclk_reg;
    logic              lrck_reg;
    logic              dat_reg;

    logic              bus_wr;
    logic              data_wr;
    logic              ctrl_wr;
    logic              pop;
    logic [31:0]       fifo_rdata;
    logic [7:0]        fifo_level;
    logic              fifo_full;
    logic              fifo_empty;

    assign bus_wr  = chipselect & ~write_n;
    assign data_wr = bus_wr & (address == ADDR_DATA);
    assign ctrl_wr = bus_wr & (address == ADDR_CTRL);
    assign pop     = (state_reg == RUN) && (cnt_reg == '0) && (slot_reg == '0);

    audioqsys_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (data_wr & ~fifo_full),
        .pop     (pop),
        .wdata   (writedata),
        .rdata   (fifo_rdata),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        enable_next = ctrl_wr ? writedata[CTRL_ENABLE_BIT] : enable_reg;
        state_next  = enable_next ? RUN : IDLE;
        cnt_next    = '0;
        slot_next   = '0;
        word_next   = '0;
        // A fresh enable starts slot 0 with an all-zero previous word.
        if (state_next == RUN && state_reg == RUN) begin
            word_next = word_reg;
            if (cnt_reg == CNT_LAST) begin
                slot_next = slot_reg + SLOT_W'(1);
                if (slot_reg == '0) begin
                    word_next = hold_reg;
                end
            end else begin
                cnt_next  = cnt_reg + CNT_W'(1);
                slot_next = slot_reg;
            end
        end
        // Slot k carries bit (32-k) mod 32, so slot 0 still shows bit 0 of the previous word.
        bit_idx = SLOT_W'(0) - slot_next;

        underflow_next = (underflow_reg & ~(ctrl_wr & writedata[CTRL_CLR_UNDER_BIT]))
                       | (pop & fifo_empty);
        overflow_next  = (overflow_reg & ~(ctrl_wr & writedata[CTRL_CLR_OVER_BIT]))
                       | (data_wr & fifo_full);

        status                   = '0;
        status[7:0]              = fifo_level;
        status[STATUS_EMPTY_BIT] = fifo_empty;
        status[STATUS_FULL_BIT]  = fifo_full;
        status[STATUS_UNDER_BIT] = underflow_reg;
        status[STATUS_OVER_BIT]  = overflow_reg;

        readdata_next = '0;
        case (address)
            ADDR_DATA:   readdata_next = '0;
            ADDR_STATUS: readdata_next = status;
            ADDR_CTRL:   readdata_next = {31'b0, enable_reg};
            ADDR_RSVD:   readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            enable_reg    <= 1'b0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            readdata_reg  <= '0;
            cnt_reg       <= '0;
            slot_reg      <= '0;
            hold_reg      <= '0;
            word_reg      <= '0;
            bclk_reg      <= 1'b0;
            lrck_reg      <= 1'b0;
            dat_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            enable_reg    <= enable_next;
            underflow_reg <= underflow_next;
            overflow_reg  <= overflow_next;
            readdata_reg  <= readdata_next;
            cnt_reg       <= cnt_next;
            slot_reg      <= slot_next;
            word_reg      <= word_next;
            if (pop) begin
                hold_reg <= fifo_empty ? 32'h0 : fifo_rdata;
            end
            bclk_reg <= (state_next == RUN) && (cnt_next >= CNT_HIGH);
            lrck_reg <= (state_next == RUN) && slot_next[SLOT_W-1];
            dat_reg  <= (state_next == RUN) && word_next[bit_idx];
        end
    end

    assign readdata    = readdata_reg;
    assign aud_bclk    = bclk_reg;
    assign aud_daclrck = lrck_reg;
    assign aud_dacdat  = dat_reg;

endmodule
